skew_feeder16: RTL and testbench
================================

# skew_feeder16

Input-skew stage placed directly upstream of the 16x16 systolic multiply array. It accepts one 16-lane A column vector and one 16-lane B row vector per handshake beat, and delays lane i by i extra cycles. This produces the diagonal wavefront the array expects on its a1..a16 and b1..b16 inputs. It also sequences a job of K beats, injects zeros on bubbles and during drain, and pulses `done` once the last products have propagated through the array.

## Interface
- `N`, 16: lane count; must match the array edge.
- `W`, 16: operand width per lane.
- `FLUSH`, 46 (3*N-2): zero-fill cycles after the final beat, before `done`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a job; sampled only in IDLE.
- `k_len`  in  8  number of beats in the job; sampled with `start`.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `a_vec`  in  N*W  A lanes; lane i = bits [W*i+W-1 : W*i].
- `b_vec`  in  N*W  B lanes, packed the same way.
- `a_out`  out  N*W  skewed A lanes; lane i drives array input a(i+1).
- `b_out`  out  N*W  skewed B lanes; lane i drives array input b(i+1).
- `busy`  out  1  high in STREAM and FLUSH.
- `done`  out  1  one-cycle pulse at job end.

## Operation
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE: `in_ready`=0.
  - `start`=1 with `k_len`≠0 → STREAM. Latch `k_len`; clear the 8-bit beat counter.
  - `start` with `k_len`=0 is ignored; the FSM stays in IDLE.
- STREAM: `in_ready`=1.
  - Each accepted beat loads lane 0 of both delay structures with the inputs and increments the beat counter.
  - A cycle without `in_valid` loads zeros (bubble). This keeps the wavefront aligned; the array accumulates 0·x = 0.
  - The cycle that accepts beat number `k_len` moves the FSM to FLUSH; the 6-bit flush counter is cleared.
- FLUSH: `in_ready`=0. Zeros enter lane 0 every cycle. After `FLUSH` cycles → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored.
- Delay structure, per operand: lane i is a shift chain of i+1 registers, giving N(N+1)/2 W-bit registers per operand.
  - Each chain shifts every cycle regardless of state. Data is already zero when no beat is taken.
  - There is no stall path; the array is free-running.
- No arithmetic is performed. Lanes pass bit-exact; no sign or width change.

## Timing
- Reset (`rst`=0, async):
  - All delay registers clear to 0, so `a_out` = `b_out` = 0.
  - State → IDLE; `in_ready`=0, `busy`=0, `done`=0.
  - Counters clear.
- Reset mid-job aborts immediately and emits no `done`. Post-reset, the first job behaves exactly as from power-up.
- Start latency: `start` high in cycle 0 → STREAM in cycle 1 (`in_ready`=1, `busy`=1).
- Lane latency: a beat accepted in cycle t appears on lane i of `a_out`/`b_out` in cycle t+1+i, for a duration of one cycle.
- Last beat accepted in cycle t:
  - `in_ready`=0 from cycle t+1.
  - FLUSH occupies cycles t+1 .. t+FLUSH.
  - `done`=1 in cycle t+FLUSH+1; `busy` falls in that same cycle.
  - IDLE from cycle t+FLUSH+2.
- Lane 15 of that last beat exits in cycle t+16. PE(16,16) receives it 15 hops later. The FLUSH default covers this with margin.
- Back-to-back jobs: `start` may be asserted in the first IDLE cycle after DONE.
- The array has no clear input. The controller must reset the array between jobs; this block does not do it.

## Test plan
- **Single beat, lane tag:** `k_len`=1; lane i of `a_vec` = i+1, lane i of `b_vec` = 0x100+i, accepted in cycle 1.
  - `a_out` lane i = i+1 in cycle 2+i only, 0 otherwise. `b_out` behaves the same way.
  - `done` in cycle 48.
- **Identity multiply:** drive `k_len`=16 back-to-back with A = B = I16 into array16x16.
  - After `done`: array c at (r,r) = 1, all other c = 0.
  - `busy` is high for exactly 16+46 cycles.
- **Bubbles:** the same identity job with `in_valid` deasserted every other cycle.
  - Array results are identical to the previous scenario.
  - `done` arrives 15 cycles later than in the back-to-back case.
- **Start filtering:**
  - `start` with `k_len`=0 → no state change, `in_ready` stays 0.
  - `start` pulsed during STREAM → ignored; the beat count is unaffected.
- **Reset mid-stream:** assert `rst`=0 after beat 7 of 16.
  - All outputs are 0 within the same cycle (async); no `done`.
  - A fresh job with `k_len`=1 then behaves exactly as in the single-beat scenario.
- **Max length:** `k_len`=255 of all-ones operands.
  - `in_ready` is high for exactly 255 accepted beats.
  - The beat counter does not wrap; `done` occurs once.

Source files
------------

// File: rtl/skew_feeder16.sv
// skew_feeder16: diagonal input skew and job sequencer for the 16x16 systolic array.
// Lane i of each operand is delayed by i extra cycles; zeros fill bubbles and drain.
module skew_feeder16 #(
    parameter int N     = 16,
    parameter int W     = 16,
    parameter int FLUSH = 3*N-2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [7:0]     k_len_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N*W-1:0] a_vec_i,
    input  logic [N*W-1:0] b_vec_i,
    output logic [N*W-1:0] a_out_o,
    output logic [N*W-1:0] b_out_o,
    output logic           busy_o,
    output logic           done_o
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] k_q, k_d;
    logic [7:0] beat_q, beat_d;
    logic [5:0] fc_q, fc_d;
    logic       take;

    assign in_ready_o = state_q == S_STREAM;
    assign busy_o     = state_q == S_STREAM || state_q == S_FLUSH;
    assign done_o     = state_q == S_DONE;
    assign take       = in_ready_o && in_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        fc_d    = fc_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && k_len_i != 8'd0) begin
                    state_d = S_STREAM;
                    k_d     = k_len_i;
                    beat_d  = '0;
                end
            end
            S_STREAM: begin
                if (in_valid_i) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == k_q - 8'd1) begin
                        state_d = S_FLUSH;
                        fc_d    = '0;
                    end
                end
            end
            S_FLUSH: begin
                fc_d = fc_q + 6'd1;
                if (fc_q == 6'(FLUSH-1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Chains shift every cycle; a non-accepted cycle injects zero so the wavefront stays aligned.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] a_q [i+1];
        logic [W-1:0] b_q [i+1];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j <= i; j++) begin
                    a_q[j] <= '0;
                    b_q[j] <= '0;
                end
            end else begin
                a_q[0] <= take ? a_vec_i[W*i +: W] : '0;
                b_q[0] <= take ? b_vec_i[W*i +: W] : '0;
                for (int j = 1; j <= i; j++) begin
                    a_q[j] <= a_q[j-1];
                    b_q[j] <= b_q[j-1];
                end
            end
        end
        assign a_out_o[W*i +: W] = a_q[i];
        assign b_out_o[W*i +: W] = b_q[i];
    end
endmodule

// File: tb/tb_skew_feeder16.sv
// tb_skew_feeder16: scoreboard bench for skew_feeder16; drivers post expected frames,
// a negedge monitor compares every cycle.
module tb_skew_feeder16;
    localparam int N = 16;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     k_len = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] a_vec = '0;
    logic [N*W-1:0] b_vec = '0;
    logic [N*W-1:0] a_out;
    logic [N*W-1:0] b_out;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [N*W-1:0] exp_a [int];
    logic [N*W-1:0] exp_b [int];
    bit             exp_rdy [int];
    bit             exp_busy [int];
    int             done_q [$];

    skew_feeder16 dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .k_len_i    (k_len),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_vec_i    (a_vec),
        .b_vec_i    (b_vec),
        .a_out_o    (a_out),
        .b_out_o    (b_out),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [N*W-1:0] ea, eb;
        bit ed;
        ea = exp_a.exists(cyc) ? exp_a[cyc] : '0;
        eb = exp_b.exists(cyc) ? exp_b[cyc] : '0;
        ed = done_q.size() > 0 && done_q[0] == cyc;
        check("a_out", a_out, ea);
        check("b_out", b_out, eb);
        check("in_ready", (N*W)'(in_ready), (N*W)'(exp_rdy.exists(cyc)));
        check("busy", (N*W)'(busy), (N*W)'(exp_busy.exists(cyc)));
        check("done", (N*W)'(done), (N*W)'(ed));
        if (ed) void'(done_q.pop_front());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] mk(input int mode, input int n, input bit isb);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       v[W*i +: W] = isb ? 16'(256 + i) : 16'(i + 1);
                1:       v[W*i +: W] = (i == n) ? 16'd1 : 16'd0;
                2:       v[W*i +: W] = 16'hFFFF;
                default: v[W*i +: W] = isb ? 16'((n + 3) * 4099 + i * 7) : 16'(((n + 1) * 257) ^ (i * 4369));
            endcase
        end
        return v;
    endfunction

    task automatic add_exp(input int c, input logic [N*W-1:0] av, input logic [N*W-1:0] bv);
        logic [N*W-1:0] t;
        for (int i = 0; i < N; i++) begin
            t = exp_a.exists(c + 1 + i) ? exp_a[c + 1 + i] : '0;
            t[W*i +: W] = av[W*i +: W];
            exp_a[c + 1 + i] = t;
            t = exp_b.exists(c + 1 + i) ? exp_b[c + 1 + i] : '0;
            t[W*i +: W] = bv[W*i +: W];
            exp_b[c + 1 + i] = t;
        end
    endtask

    // done_off: hand-computed cycle of done relative to the start cycle
    task automatic run_job(input int k, input int mode, input bit bubbles, input int abort_after,
                           input bit mid_start, input int done_off);
        int s, c, n, last, ph;
        bit v;
        s = cyc;
        start = 1'b1;
        k_len = k[7:0];
        if (abort_after == 0) done_q.push_back(s + done_off);
        step();
        start = 1'b0;
        k_len = 8'd0;
        n = 0;
        ph = 0;
        last = 0;
        while (n < k) begin
            c = cyc;
            exp_rdy[c] = 1'b1;
            exp_busy[c] = 1'b1;
            v = !(bubbles && ph[0]);
            ph++;
            in_valid = v;
            a_vec = mk(mode, n, 1'b0);
            b_vec = mk(mode, n, 1'b1);
            if (mid_start && n == 2) begin
                start = 1'b1;
                k_len = 8'd3;
            end
            if (v) begin
                add_exp(c, a_vec, b_vec);
                n++;
                last = c;
            end
            step();
            start = 1'b0;
            k_len = 8'd0;
            in_valid = 1'b0;
            if (abort_after != 0 && n == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("abort_a_out", a_out, '0);
                check("abort_b_out", b_out, '0);
                check("abort_flags", (N*W)'({in_ready, busy, done}), '0);
                exp_a.delete();
                exp_b.delete();
                exp_rdy.delete();
                exp_busy.delete();
                step();
                rst_n = 1'b1;
                step();
                return;
            end
        end
        for (int j = 1; j <= 46; j++) exp_busy[last + j] = 1'b1;
        // Offer junk during drain; none of it may be accepted.
        while (cyc < s + done_off + 1 && cyc < s + 2000) begin
            in_valid = 1'b1;
            a_vec = '1;
            b_vec = '1;
            step();
        end
        in_valid = 1'b0;
        a_vec = '0;
        b_vec = '0;
    endtask

    initial begin
        step();
        step();
        check("reset_a_out", a_out, '0);
        check("reset_b_out", b_out, '0);
        rst_n = 1'b1;
        step();
        step();
        run_job(1, 0, 1'b0, 0, 1'b0, 48);
        start = 1'b1;
        k_len = 8'd0;
        step();
        start = 1'b0;
        step();
        check("k0_in_ready", (N*W)'(in_ready), '0);
        run_job(16, 1, 1'b0, 0, 1'b0, 63);
        run_job(16, 1, 1'b1, 0, 1'b0, 78);
        run_job(5, 3, 1'b0, 0, 1'b1, 52);
        run_job(16, 3, 1'b0, 7, 1'b0, 0);
        run_job(1, 0, 1'b0, 0, 1'b0, 48);
        run_job(255, 2, 1'b0, 0, 1'b0, 302);
        step();
        step();
        check("done_queue_empty", (N*W)'(done_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
